// File: rtl/width_converter_8ton.sv
// width_converter_8ton
//   Packs an 8-bit byte stream from the I3C target FSM into Width-bit words
//   for the TTI RX queue, least-significant byte first. One output word
//   register decouples the byte stream from the queue. An end-of-transfer
//   flush emits a partial, zero-padded word together with its byte count.
//
// Ports
//   clk_i           clock
//   rst_i           synchronous active-high reset
//   sink_valid_i    byte valid from the target FSM
//   sink_ready_o    converter accepts a byte (depends on state only)
//   sink_data_i     received byte
//   sink_flush_i    single-cycle end-of-transfer pulse
//   source_valid_o  output word valid
//   source_ready_i  RX queue accepts the word
//   source_data_o   packed word, byte k in bits [8k+7:8k]
//   source_bytes_o  number of valid bytes in source_data_o (1..Bytes)

module width_converter_8ton #(
    parameter int Width = 32
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             sink_valid_i,
    output logic                             sink_ready_o,
    input  logic [7:0]                       sink_data_i,
    input  logic                             sink_flush_i,
    output logic                             source_valid_o,
    input  logic                             source_ready_i,
    output logic [Width-1:0]                 source_data_o,
    output logic [$clog2(Width/8):0]         source_bytes_o
);

    localparam int Bytes = Width / 8;
    localparam int CW    = $clog2(Bytes) + 1;
    localparam logic [CW-1:0] BytesC = CW'(Bytes);

    logic [Width-1:0] acc_q, acc_d;
    logic [CW-1:0]    bcnt_q, bcnt_d;
    logic             fpend_q, fpend_d;
    logic             out_valid_q, out_valid_d;
    logic [Width-1:0] out_data_q, out_data_d;
    logic [CW-1:0]    out_bytes_q, out_bytes_d;

    logic             sink_ready;
    logic             accept;
    logic             ofree;
    logic             emit;
    logic [Width-1:0] acc_new;
    logic [CW-1:0]    cnt_new;
    logic             full_new;
    logic             flush_eff;

    assign sink_ready = (bcnt_q != BytesC) && !fpend_q;
    assign accept     = sink_valid_i && sink_ready;
    assign ofree      = !out_valid_q || source_ready_i;

    always_comb begin
        acc_new = acc_q;
        cnt_new = bcnt_q;
        if (accept) begin
            for (int unsigned k = 0; k < Bytes; k++) begin
                if (bcnt_q == CW'(k)) begin
                    acc_new[8*k +: 8] = sink_data_i;
                end
            end
            cnt_new = bcnt_q + CW'(1);
        end
        full_new  = (cnt_new == BytesC);
        flush_eff = sink_flush_i && (cnt_new != '0);
    end

    always_comb begin
        acc_d       = acc_new;
        bcnt_d      = cnt_new;
        fpend_d     = fpend_q;
        out_valid_d = out_valid_q && !source_ready_i;
        out_data_d  = out_data_q;
        out_bytes_d = out_bytes_q;
        emit        = 1'b0;

        // A sealed group (pending flush or parked full word) leaves the
        // sink stalled, so acc_new/cnt_new equal the held state here and
        // a repeated flush pulse changes nothing.
        if (fpend_q || (bcnt_q == BytesC)) begin
            emit = ofree;
        end else if (full_new || flush_eff) begin
            emit = ofree;
            if (!ofree && flush_eff) begin
                fpend_d = 1'b1;
            end
        end

        if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_new;
            out_bytes_d = cnt_new;
            acc_d       = '0;
            bcnt_d      = '0;
            fpend_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q       <= '0;
            bcnt_q      <= '0;
            fpend_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_bytes_q <= '0;
        end else begin
            acc_q       <= acc_d;
            bcnt_q      <= bcnt_d;
            fpend_q     <= fpend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_bytes_q <= out_bytes_d;
        end
    end

    assign sink_ready_o   = sink_ready;
    assign source_valid_o = out_valid_q;
    assign source_data_o  = out_data_q;
    assign source_bytes_o = out_bytes_q;

endmodule

// File: tb/tb_width_converter_8ton.sv
module tb_width_converter_8ton;

    localparam int W  = 32;
    localparam int NB = W / 8;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         sink_valid_i = 1'b0;
    logic         sink_ready_o;
    logic [7:0]   sink_data_i = '0;
    logic         sink_flush_i = 1'b0;
    logic         source_valid_o;
    logic         source_ready_i = 1'b0;
    logic [W-1:0] source_data_o;
    logic [2:0]   source_bytes_o;

    int checks = 0;
    int errors = 0;

    // Reference model: list of bytes collected for the current word, a
    // "sealed" flag for a flushed group waiting on the output, and the
    // output register contents.
    byte unsigned      pend[$];
    bit                sealed;
    bit                m_valid;
    logic [W-1:0]      m_data;
    int                m_bytes;

    width_converter_8ton #(.Width(W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .sink_valid_i   (sink_valid_i),
        .sink_ready_o   (sink_ready_o),
        .sink_data_i    (sink_data_i),
        .sink_flush_i   (sink_flush_i),
        .source_valid_o (source_valid_o),
        .source_ready_i (source_ready_i),
        .source_data_o  (source_data_o),
        .source_bytes_o (source_bytes_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready();
        return (pend.size() < NB) && !sealed;
    endfunction

    task automatic model_reset();
        pend.delete();
        sealed  = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_bytes = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, 64'(source_valid_o), 64'(m_valid));
        check({tag, ".data"},  64'(source_data_o),  64'(m_data));
        check({tag, ".bytes"}, 64'(source_bytes_o), 64'(m_bytes));
        check({tag, ".ready"}, 64'(sink_ready_o),   64'(model_ready()));
    endtask

    // One clock cycle: drive inputs, check sink_ready before the edge,
    // advance the model across the edge, then check all outputs.
    task automatic step(input bit v, input byte unsigned d, input bit f,
                        input bit r, input bit rs, input string tag);
        bit rdy, ofree;
        logic [W-1:0] w;
        sink_valid_i   = v;
        sink_data_i    = d;
        sink_flush_i   = f;
        source_ready_i = r;
        rst_i          = rs;
        rdy = model_ready();
        if (!rs) check({tag, ".pre_ready"}, 64'(sink_ready_o), 64'(rdy));
        @(posedge clk_i);
        if (rs) begin
            model_reset();
        end else begin
            ofree = !m_valid || r;
            if (v && rdy) pend.push_back(d);
            if (f && pend.size() > 0) sealed = 1'b1;
            if (ofree && (sealed || pend.size() == NB)) begin
                w = '0;
                foreach (pend[i]) w = w | (W'(pend[i]) << (8 * i));
                m_valid = 1'b1;
                m_data  = w;
                m_bytes = pend.size();
                pend.delete();
                sealed  = 1'b0;
            end else if (m_valid && r) begin
                m_valid = 1'b0;
            end
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        model_reset();
        rst_i = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        check_outputs("reset");
        check("reset.ready_one", 64'(sink_ready_o), 64'(1));

        // 1: single word, consecutive bytes
        step(1, 8'h11, 0, 1, 0, "t1b0");
        step(1, 8'h22, 0, 1, 0, "t1b1");
        step(1, 8'h33, 0, 1, 0, "t1b2");
        step(1, 8'h44, 0, 1, 0, "t1b3");
        check("t1.word", 64'(source_data_o), 64'h44332211);
        check("t1.bytes", 64'(source_bytes_o), 64'd4);
        step(0, 8'h00, 0, 1, 0, "t1idle");

        // 2: two back-to-back words, no stalls
        for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 1, 0, "t2");
        check("t2.word2", 64'(source_data_o), 64'h08070605);
        step(0, 8'h00, 0, 1, 0, "t2idle");

        // 3: second word parks while the queue is stalled
        for (int i = 1; i <= 4; i++) step(1, 8'(i), 0, 1, 0, "t3a");
        for (int i = 5; i <= 8; i++) step(1, 8'(i), 0, 0, 0, "t3b");
        check("t3.stall", 64'(sink_ready_o), 64'd0);
        check("t3.held", 64'(source_data_o), 64'h04030201);
        step(0, 8'h00, 0, 1, 0, "t3rel");
        check("t3.word2", 64'(source_data_o), 64'h08070605);
        step(0, 8'h00, 0, 1, 0, "t3drain");

        // 4: flush together with the last byte; flush on empty is a no-op
        step(1, 8'hAA, 0, 1, 0, "t4a");
        step(1, 8'hBB, 0, 1, 0, "t4b");
        step(1, 8'hCC, 1, 1, 0, "t4c");
        check("t4.word", 64'(source_data_o), 64'h00CCBBAA);
        check("t4.bytes", 64'(source_bytes_o), 64'd3);
        step(0, 8'h00, 1, 1, 0, "t4empty");
        check("t4.noword", 64'(source_valid_o), 64'd0);

        // 5: flush while output busy, second flush absorbed
        for (int i = 0; i < 4; i++) step(1, 8'(8'h50 + i), 0, 0, 0, "t5w");
        step(1, 8'hE1, 0, 0, 0, "t5b0");
        step(1, 8'hE2, 1, 0, 0, "t5f1");
        check("t5.fpend_ready", 64'(sink_ready_o), 64'd0);
        step(1, 8'hE3, 1, 0, 0, "t5f2");
        step(0, 8'h00, 0, 1, 0, "t5rel");
        check("t5.word", 64'(source_data_o), 64'h0000E2E1);
        check("t5.bytes", 64'(source_bytes_o), 64'd2);
        step(0, 8'h00, 0, 1, 0, "t5done");
        check("t5.onlyone", 64'(source_valid_o), 64'd0);

        // 6: reset with partial word and output pending
        for (int i = 0; i < 4; i++) step(1, 8'(8'h60 + i), 0, 0, 0, "t6w");
        for (int i = 0; i < 3; i++) step(1, 8'(8'h70 + i), 0, 0, 0, "t6p");
        step(0, 8'h00, 0, 0, 1, "t6rst");
        check("t6.valid", 64'(source_valid_o), 64'd0);
        check("t6.ready", 64'(sink_ready_o), 64'd1);
        for (int i = 0; i < 4; i++) step(1, 8'(8'h80 + i), 0, 1, 0, "t6n");
        check("t6.word", 64'(source_data_o), 64'h83828180);
        check("t6.bytes", 64'(source_bytes_o), 64'd4);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) != 0, 8'($urandom), ($urandom % 7) == 0,
                 ($urandom % 3) != 0, ($urandom % 150) == 0, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/width_converter_8ton.md
Name: width_converter_8toN

Overview:
- Bus width converter from 8-bit to N-bit, where N is a multiple of 8.
- Sits between the I3C target FSM and the TTI RX queue. It packs received bytes into N-bit words, least-significant byte first.
- Decouples the byte stream from the queue with one output word register. The FSM can keep delivering bytes while a completed word waits for the queue.
- An end-of-transfer flush emits a partial word, zero-padded, together with its valid byte count.

Parameters:
- Width, 32, output word width in bits; must be a multiple of 8 and at least 16.
- Bytes (localparam), Width/8, bytes per word.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-high reset.
- sink_valid_i  input  1  byte valid from the target FSM.
- sink_ready_o  output  1  converter accepts a byte.
- sink_data_i  input  8  received byte.
- sink_flush_i  input  1  single-cycle end-of-transfer pulse.
- source_valid_o  output  1  output word valid to the RX queue.
- source_ready_i  input  1  RX queue accepts the word.
- source_data_o  output  Width  packed word; byte k is in bits [8k+7:8k].
- source_bytes_o  output  $clog2(Bytes)+1  number of valid bytes in source_data_o, from 1 to Bytes.

Behaviour:

Clocking and reset:
- One clock; reset is synchronous and active-high (clk_i, rst_i).
- Reset values:
  - Accumulator acc and byte count bcnt: 0.
  - Flush-pending flag fpend: 0.
  - source_valid_o, source_data_o, source_bytes_o: 0.
  - sink_ready_o: 1 in the first cycle after reset.
- Reset asserted mid-word or mid-flush discards all held data; no word is emitted.

Handshakes:
- Sink handshake: sink_valid_i & sink_ready_o.
- Source handshake: source_valid_o & source_ready_i.
- Output slot is free (ofree) when !source_valid_o | source_ready_i.
- sink_ready_o = (bcnt != Bytes) & !fpend. This is combinational from state only; it never depends on sink_valid_i.

Byte accept:
- An accepted byte is written to acc[8*bcnt +: 8], and bcnt increments.
- Byte lanes at or above bcnt read as 0 in any emitted word.

Full word (1-cycle latency):
- If the accepted byte completes the word (bcnt == Bytes-1) and ofree:
  - On the same edge, the output register loads the full word and source_bytes_o = Bytes.
  - source_valid_o = 1, bcnt = 0, acc cleared.
- If the output slot is not free:
  - bcnt = Bytes, so sink_ready_o = 0.
  - The word transfers on the first edge where ofree holds; then bcnt = 0.

Flush:
- Sampled every cycle. A byte accepted in the same cycle as the flush is included in the flushed word.
- Resulting count 0: flush is a no-op; no empty word is ever emitted.
- Resulting count c > 0 and ofree: output loads acc zero-padded, with source_bytes_o = c, on that edge. bcnt = 0, acc cleared.
- Resulting count c > 0 and output busy: fpend = 1 and sink_ready_o = 0. The transfer happens when ofree, then fpend clears.
- A flush arriving while fpend is already 1 is absorbed (idempotent).
- A flush that completes exactly Bytes bytes emits a full word with source_bytes_o = Bytes.

Output register:
- Holds data and count stable while source_valid_o & !source_ready_i.
- Clears source_valid_o on a source handshake unless reloaded on the same edge.
- Back-to-back operation: one byte per cycle sustains full throughput when source_ready_i = 1, i.e. one word per Bytes cycles with no bubbles.

Test Plan:
1. Width=32, ready=1; feed bytes 11,22,33,44 on consecutive cycles.
   - Expect source_data_o = 0x44332211, source_bytes_o = 4, valid exactly 1 cycle after the 4th byte.
   - sink_ready_o stays 1 throughout.
2. Width=32; feed 8 bytes 01..08 back-to-back with source_ready_i = 1.
   - Expect words 0x04030201 then 0x08070605, both with bytes = 4, and no sink stalls.
3. Hold source_ready_i = 0 after the first word; feed 8 bytes.
   - Second word parks in acc and sink_ready_o drops after byte 8.
   - Raise ready: expect 0x04030201, then 0x08070605 on the next cycle; sink_ready_o returns to 1.
4. Feed AA,BB, then pulse sink_flush_i together with byte CC.
   - Expect source_data_o = 0x00CCBBAA, source_bytes_o = 3.
   - A flush with bcnt = 0 and no byte produces no word.
5. Output busy (ready = 0) while flushing 2 bytes.
   - fpend is set, sink_ready_o = 0, and a second flush pulse is ignored.
   - On ready: exactly one word with bytes = 2 is emitted, then sink_ready_o = 1.
6. Assert rst_i after 3 bytes and with an output word pending.
   - Next cycle: source_valid_o = 0, sink_ready_o = 1.
   - Then 4 new bytes yield a clean word with bytes = 4.
